// File: rtl/uart_rx_sample_ctrl.sv
// uart_rx_sample_ctrl: receive-side sequencer for an oversampled UART line.
// Synchronises rx_in and finds the start bit. Samples every bit at mid-bit
// and drives the shift strobe for the receive shift register. Checks the stop
// bit, then reports either a good character or a framing error.
module uart_rx_sample_ctrl #(
    parameter int OVERSAMPLE = 16,  // clk cycles per bit; even, >= 4
    parameter int DATA_BITS  = 8    // data bits per character, LSB first, 1..16
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active-low
    input  logic                 enable,
    input  logic                 rx_in,
    output logic                 sample_en,
    output logic                 sr_shift,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 char_ready,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Start-bit centre: counted from the first low sample.
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    // One full bit period between consecutive mid-bit samples.
    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BITS_MAX  = BW'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [SW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_meta;
    logic                 rx_s;

    // Two-flop synchroniser for the asynchronous line; it resets to the idle
    // level, so a reset never looks like a start bit. It keeps running while
    // the receiver is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample
            // simultaneously; with blocking assignments rx_in would pass
            // straight through to rx_s in one cycle.
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Frame sequencer. All outputs are registered: the strobes pulse for one
    // cycle, and busy/sample_en follow the state one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            sample_en  <= 1'b0;
            sr_shift   <= 1'b0;
            char_ready <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Strobes default low; only the sampling branches raise them.
            sr_shift   <= 1'b0;
            char_ready <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= (state != IDLE);
            sample_en  <= (state != IDLE);

            if (!enable) begin
                // Drop any partial character. rx_data keeps its last good value.
                state    <= IDLE;
                samp_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            samp_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end

                    START: begin
                        if (samp_cnt == HALF_LAST) begin
                            // Low at the centre confirms the start bit.
                            // High means a glitch; drop back silently.
                            state    <= rx_s ? IDLE : DATA;
                            samp_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            samp_cnt <= samp_cnt + SW'(1);
                        end
                    end

                    DATA: begin
                        if (samp_cnt == BIT_LAST) begin
                            // LSB arrives first, so new bits enter at the top.
                            shreg    <= DATA_BITS'({rx_s, shreg} >> 1);
                            sr_shift <= 1'b1;
                            samp_cnt <= '0;
                            if (bit_cnt == BITS_LAST) begin
                                state   <= STOP;
                                bit_cnt <= '0;
                            end else if (bit_cnt != BITS_MAX) begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            samp_cnt <= samp_cnt + SW'(1);
                        end
                    end

                    STOP: begin
                        if (samp_cnt == BIT_LAST) begin
                            if (rx_s) begin
                                rx_data    <= shreg;
                                char_ready <= 1'b1;
                            end else begin
                                frame_err  <= 1'b1;
                            end
                            state    <= IDLE;
                            samp_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            samp_cnt <= samp_cnt + SW'(1);
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sample_ctrl.sv
// tb_uart_rx_sample_ctrl: directed and randomized frames on rx_in. The
// results are compared with a frame-level reference model. Each frame gives
// DATA_BITS shift strobes spaced one bit apart. A stop bit of 1 gives one
// character, and a stop bit of 0 gives one framing error.
module tb_uart_rx_sample_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          rx_in = 1'b1;
    logic          sample_en;
    logic          sr_shift;
    logic [DB-1:0] rx_data;
    logic          char_ready;
    logic          frame_err;
    logic          busy;

    uart_rx_sample_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx_in      (rx_in),
        .sample_en  (sample_en),
        .sr_shift   (sr_shift),
        .rx_data    (rx_data),
        .char_ready (char_ready),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Event log collected by the monitor.
    int            shift_t[$];
    int            char_t[$];
    logic [DB-1:0] char_v[$];
    int            err_n     = 0;
    bit            busy_seen = 1'b0;

    // Reference model state.
    logic [DB-1:0] exp_q[$];
    int            exp_err;
    logic [DB-1:0] exp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter on the active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples the outputs on the falling edge, away from updates.
    always @(negedge clk) begin
        if (sr_shift) shift_t.push_back(cyc);
        if (char_ready) begin
            char_t.push_back(cyc);
            char_v.push_back(rx_data);
        end
        if (frame_err) err_n = err_n + 1;
        if (busy) busy_seen = 1'b1;
        if (char_ready || frame_err)
            check("pulse_exclusive", {31'b0, char_ready & frame_err}, 32'd0);
    end

    task automatic clear_log();
        shift_t.delete();
        char_t.delete();
        char_v.delete();
        err_n     = 0;
        busy_seen = 1'b0;
    endtask

    // Drives one bit period. Called on a falling edge.
    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Checks that the shift strobes of one frame are exactly one bit apart.
    task automatic check_spacing(input int base);
        for (int i = 1; i < DB; i++)
            check("shift_gap", shift_t[base+i] - shift_t[base+i-1], OS);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},       {31'b0, busy},       32'd0);
        check({tag, "_sample_en"},  {31'b0, sample_en},  32'd0);
        check({tag, "_sr_shift"},   {31'b0, sr_shift},   32'd0);
        check({tag, "_char_ready"}, {31'b0, char_ready}, 32'd0);
        check({tag, "_frame_err"},  {31'b0, frame_err},  32'd0);
    endtask

    initial begin
        logic [DB-1:0] d;
        logic          stop;
        int            nframes;

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_rx_data", rx_data, 0);
        rst    = 1'b1;
        enable = 1'b1;
        idle_bits(2);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // 1: good 0xA5 frame.
        clear_log();
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        check("t1_shifts", shift_t.size(), DB);
        if (shift_t.size() == DB) check_spacing(0);
        check("t1_chars", char_v.size(), 1);
        check("t1_errs", err_n, 0);
        check("t1_rx_data", rx_data, 8'hA5);

        // 2: short glitch is a false start.
        clear_log();
        send_bit(1'b1);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        check("t2_busy_seen", {31'b0, busy_seen}, 32'd1);
        check("t2_busy_after", {31'b0, busy}, 32'd0);
        check("t2_shifts", shift_t.size(), 0);
        check("t2_chars", char_v.size(), 0);
        check("t2_errs", err_n, 0);

        // 3: 0x3C with the stop bit low.
        clear_log();
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        check("t3_shifts", shift_t.size(), DB);
        check("t3_errs", err_n, 1);
        check("t3_chars", char_v.size(), 0);
        check("t3_rx_data", rx_data, 8'hA5);

        // 4: back-to-back 0x01 and 0xFF with no idle gap.
        clear_log();
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(2);
        check("t4_chars", char_v.size(), 2);
        if (char_v.size() == 2) begin
            check("t4_first", char_v[0], 8'h01);
            check("t4_second", char_v[1], 8'hFF);
            check("t4_char_gap", char_t[1] - char_t[0], (DB + 2) * OS);
        end
        check("t4_shifts", shift_t.size(), 2 * DB);
        if (shift_t.size() == 2 * DB) begin
            check_spacing(0);
            check_spacing(DB);
        end

        // 5: enable dropped after the third data bit, then 0x5A.
        clear_log();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        enable = 1'b0;
        for (int i = 0; i < DB - 3; i++) send_bit(1'b0);
        send_bit(1'b1);
        idle_bits(1);
        check_idle_outputs("t5_disabled");
        enable = 1'b1;
        idle_bits(1);
        check("t5_abort_shifts", shift_t.size(), 3);
        check("t5_abort_chars", char_v.size(), 0);
        check("t5_abort_errs", err_n, 0);
        check("t5_held", rx_data, 8'hFF);
        clear_log();
        send_frame(8'h5A, 1'b1);
        idle_bits(2);
        check("t5_chars", char_v.size(), 1);
        check("t5_rx_data", rx_data, 8'h5A);

        // 6: asynchronous reset in the middle of DATA.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        check("t6_rx_data", rx_data, 0);
        @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        idle_bits(3);
        clear_log();
        send_frame(8'h81, 1'b1);
        idle_bits(2);
        check("t6_chars", char_v.size(), 1);
        check("t6_rx_data", rx_data, 8'h81);

        // Random frames against the frame-level model.
        clear_log();
        exp_q.delete();
        exp_err  = 0;
        exp_data = 8'h81;
        nframes  = 12;
        for (int f = 0; f < nframes; f++) begin
            d    = DB'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            if (stop) begin
                exp_q.push_back(d);
                exp_data = d;
                idle_bits($urandom_range(0, 2));
            end else begin
                exp_err++;
                idle_bits($urandom_range(1, 2));
            end
        end
        idle_bits(2);
        check("rnd_shifts", shift_t.size(), nframes * DB);
        if (shift_t.size() == nframes * DB)
            for (int f = 0; f < nframes; f++) check_spacing(f * DB);
        check("rnd_chars", char_v.size(), exp_q.size());
        if (char_v.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++) check("rnd_char", char_v[i], exp_q[i]);
        check("rnd_errs", err_n, exp_err);
        check("rnd_rx_data", rx_data, exp_data);
        check("rnd_busy_end", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
